ball_ctrl: RTL and testbench

- Ball-motion and goal-detection stage of the pong game; sits directly upstream of the score/LED block and drives its p1vic/p2vic inputs.
- Moves a ball on a FIELD_W x FIELD_H grid at a prescaled step rate, bouncing off top/bottom walls and paddles.
- Emits a one-cycle goal pulse when a player misses, then re-serves from centre. Freezes when the score block asserts game_over.

---
 rtl/pong_pkg.sv | 17 +
 rtl/step_timer.sv | 34 +++
 rtl/ball_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ball_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and field geometry for the pong ball/paddle datapath.
package pong_pkg;

  localparam int FIELD_W    = 16;
  localparam int FIELD_H    = 8;
  localparam int PADDLE_LEN = 3;
  localparam int XW         = $clog2(FIELD_W);
  localparam int YW         = $clog2(FIELD_H);

  typedef enum logic [1:0] {SERVE, MOVE, GOAL, FROZEN} ball_state_t;

  // Direction of travel on one axis.
  typedef logic dir_t;
  localparam dir_t DIR_NEG = 1'b0;
  localparam dir_t DIR_POS = 1'b1;

endpackage

// File: rtl/step_timer.sv
// Prescaler: one-cycle step every TICK_DIV enabled clocks, clearable at any time.
// Shared by ball motion and paddle-speed limiting.
module step_timer #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // step does not look at clr_i, so a caller may derive clr_i from a step-driven next state
  assign step_o = en_i && (cnt_q == LAST);

  // NOTE: every signal written here gets a default first; a branch that skips it would infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_ctrl.sv
// Ball motion, wall/paddle bounces and goal detection for pong; goal pulses
// feed the score block, whose game_over freezes play.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int FIELD_W     = pong_pkg::FIELD_W,
  parameter int FIELD_H     = pong_pkg::FIELD_H,
  parameter int PADDLE_LEN  = pong_pkg::PADDLE_LEN,
  parameter int TICK_DIV    = 25_000_000,
  parameter int SERVE_DELAY = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       game_over,
  input  logic [$clog2(FIELD_H)-1:0] p1_pos,
  input  logic [$clog2(FIELD_H)-1:0] p2_pos,
  output logic [$clog2(FIELD_W)-1:0] ball_x,
  output logic [$clog2(FIELD_H)-1:0] ball_y,
  output logic                       p1vic,
  output logic                       p2vic
);

  localparam int XW   = $clog2(FIELD_W);
  localparam int YW   = $clog2(FIELD_H);
  localparam int CNTW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [XW-1:0]   X_CTR   = XW'(FIELD_W / 2);
  localparam logic [YW-1:0]   Y_CTR   = YW'(FIELD_H / 2);
  localparam logic [XW-1:0]   X_LAST  = XW'(FIELD_W - 1);
  localparam logic [XW-1:0]   X_P2HIT = XW'(FIELD_W - 2);
  localparam logic [XW-1:0]   X_P2RET = XW'(FIELD_W - 3);
  localparam logic [YW-1:0]   Y_LAST  = YW'(FIELD_H - 1);
  localparam logic [CNTW-1:0] CNT_END = CNTW'(SERVE_DELAY - 1);

  ball_state_t     state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  dir_t            dx_q, dx_d, dy_q, dy_d, dy_v;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pend_p1_q, pend_p1_d, pend_p2_q, pend_p2_d;
  logic            p1vic_q, p1vic_d, p2vic_q, p2vic_d;
  logic            step, tmr_clr;

  // One extra bit keeps top+PADDLE_LEN-1 from wrapping; rows past the field simply never match.
  function automatic logic in_paddle(input logic [YW-1:0] top, input logic [YW-1:0] y);
    logic [YW:0] lo, hi, yy;
    lo = {1'b0, top};
    hi = lo + (YW+1)'(PADDLE_LEN - 1);
    yy = {1'b0, y};
    return (yy >= lo) && (yy <= hi);
  endfunction

  assign tmr_clr = game_over || (state_d != state_q);

  step_timer #(.TICK_DIV(TICK_DIV)) u_step_timer (
    .clk    (clock),
    .rst_n  (reset),
    .en_i   (!game_over),
    .clr_i  (tmr_clr),
    .step_o (step)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    dy_v      = dy_q;
    cnt_d     = cnt_q;
    pend_p1_d = 1'b0;
    pend_p2_d = 1'b0;
    p1vic_d   = pend_p1_q && !game_over;
    p2vic_d   = pend_p2_q && !game_over;

    if (game_over) begin
      state_d = FROZEN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FROZEN: begin
          x_d     = X_CTR;
          y_d     = Y_CTR;
          dy_d    = DIR_POS;
          state_d = SERVE;
          cnt_d   = '0;
        end
        SERVE: if (step) begin
          if (cnt_q == CNT_END) begin
            state_d = MOVE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        GOAL: if (step) begin
          if (cnt_q == CNT_END) begin
            // Serve toward whoever conceded: the ball sits on that player's goal column.
            dx_d    = (x_q == X_LAST) ? DIR_POS : DIR_NEG;
            dy_d    = DIR_POS;
            x_d     = X_CTR;
            y_d     = Y_CTR;
            state_d = SERVE;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        MOVE: if (step) begin
          if ((y_q == '0 && dy_q == DIR_NEG) || (y_q == Y_LAST && dy_q == DIR_POS)) dy_v = ~dy_q;
          dy_d = dy_v;
          y_d  = (dy_v == DIR_POS) ? y_q + 1'b1 : y_q - 1'b1;

          if (x_q == XW'(1) && dx_q == DIR_NEG) begin
            if (in_paddle(p1_pos, y_q)) begin
              dx_d = DIR_POS;
              x_d  = XW'(2);
            end else begin
              x_d       = '0;
              pend_p2_d = 1'b1;
              state_d   = GOAL;
              cnt_d     = '0;
            end
          end else if (x_q == X_P2HIT && dx_q == DIR_POS) begin
            if (in_paddle(p2_pos, y_q)) begin
              dx_d = DIR_NEG;
              x_d  = X_P2RET;
            end else begin
              x_d       = X_LAST;
              pend_p1_d = 1'b1;
              state_d   = GOAL;
              cnt_d     = '0;
            end
          end else begin
            x_d = (dx_q == DIR_POS) ? x_q + 1'b1 : x_q - 1'b1;
          end
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= SERVE;
      x_q       <= X_CTR;
      y_q       <= Y_CTR;
      dx_q      <= DIR_POS;
      dy_q      <= DIR_POS;
      cnt_q     <= '0;
      pend_p1_q <= 1'b0;
      pend_p2_q <= 1'b0;
      p1vic_q   <= 1'b0;
      p2vic_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      cnt_q     <= cnt_d;
      pend_p1_q <= pend_p1_d;
      pend_p2_q <= pend_p2_d;
      p1vic_q   <= p1vic_d;
      p2vic_q   <= p2vic_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign p1vic  = p1vic_q;
  assign p2vic  = p2vic_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl at TICK_DIV=1: a rule-level model compared every cycle,
// plus directed scenarios with hand-computed positions.
module tb_ball_ctrl;
  import pong_pkg::*;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int PL = 3;
  localparam int SD = 4;

  localparam int M_SERVE  = 0;
  localparam int M_MOVE   = 1;
  localparam int M_GOAL   = 2;
  localparam int M_FROZEN = 3;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_over = 1'b0;
  logic [2:0] p1_pos = '0;
  logic [2:0] p2_pos = '0;
  logic [3:0] ball_x;
  logic [2:0] ball_y;
  logic       p1vic, p2vic;

  int n_checks = 0;
  int n_fail   = 0;

  ball_ctrl #(.TICK_DIV(1)) dut (
    .clock     (clock),
    .reset     (rst_n),
    .game_over (game_over),
    .p1_pos    (p1_pos),
    .p2_pos    (p2_pos),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .p1vic     (p1vic),
    .p2vic     (p2vic)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rule-level model: position, signed directions, steps left in the current hold.
  int mx = W / 2, my = H / 2, mdx = 1, mdy = 1;
  int mode = M_SERVE, mleft = SD;
  bit pend1 = 1'b0, pend2 = 1'b0, e1 = 1'b0, e2 = 1'b0;

  task automatic model_reset();
    mx = W / 2; my = H / 2; mdx = 1; mdy = 1;
    mode = M_SERVE; mleft = SD;
    pend1 = 1'b0; pend2 = 1'b0; e1 = 1'b0; e2 = 1'b0;
  endtask

  function automatic bit covers(input int top, input int y);
    return (y >= top) && (y < top + PL);
  endfunction

  task automatic model_edge();
    int nx, ny;
    e1 = pend1 && !game_over;
    e2 = pend2 && !game_over;
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (game_over) begin
      mode = M_FROZEN;
      return;
    end
    case (mode)
      M_FROZEN: begin
        mx = W / 2; my = H / 2; mdy = 1;
        mode = M_SERVE; mleft = SD;
      end
      M_SERVE: begin
        mleft--;
        if (mleft == 0) mode = M_MOVE;
      end
      M_GOAL: begin
        mleft--;
        if (mleft == 0) begin
          mdx = (mx == W - 1) ? 1 : -1;
          mx = W / 2; my = H / 2; mdy = 1;
          mode = M_SERVE; mleft = SD;
        end
      end
      default: begin
        if ((my == 0 && mdy < 0) || (my == H - 1 && mdy > 0)) mdy = -mdy;
        ny = my + mdy;
        if (mx == 1 && mdx < 0) begin
          if (covers(int'(p1_pos), my)) begin mdx = 1; nx = 2; end
          else begin nx = 0; pend2 = 1'b1; mode = M_GOAL; mleft = SD; end
        end else if (mx == W - 2 && mdx > 0) begin
          if (covers(int'(p2_pos), my)) begin mdx = -1; nx = W - 3; end
          else begin nx = W - 1; pend1 = 1'b1; mode = M_GOAL; mleft = SD; end
        end else begin
          nx = mx + mdx;
        end
        mx = nx;
        my = ny;
      end
    endcase
  endtask

  initial forever begin
    @(posedge clock or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_edge();
  end

  initial forever begin
    @(negedge clock);
    check("model_x", ball_x, mx);
    check("model_y", ball_y, my);
    check("model_p1vic", p1vic, e1);
    check("model_p2vic", p2vic, e2);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 rst_n = 1'b0;
    @(negedge clock);
    #2 rst_n = 1'b1;
  endtask

  task automatic expect_xy(input string name, input int x, input int y);
    check({name, "_x"}, ball_x, x);
    check({name, "_y"}, ball_y, y);
  endtask

  int path_x [7] = '{9, 10, 11, 12, 13, 14, 15};
  int path_y [7] = '{5, 6, 7, 6, 5, 4, 3};

  initial begin
    // P2 miss from a fresh serve, then the goal hold and re-serve toward P2.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      expect_xy("serve_hold", 8, 4);
    end
    for (int k = 0; k < 7; k++) begin
      cyc(1);
      expect_xy("p2_miss_path", path_x[k], path_y[k]);
      check("p1vic_before_pulse", p1vic, 0);
    end
    cyc(1);
    check("p1vic_pulse", p1vic, 1);
    check("p2vic_quiet", p2vic, 0);
    check("goal_col_1", ball_x, 15);
    cyc(1);
    check("p1vic_one_wide", p1vic, 0);
    check("goal_col_2", ball_x, 15);
    cyc(1);
    check("goal_col_3", ball_x, 15);
    cyc(1);
    expect_xy("recentre", 8, 4);
    cyc(4);
    expect_xy("reserve_hold", 8, 4);
    cyc(1);
    expect_xy("reserve_toward_p2", 9, 5);

    // Paddle hits on both sides, ending in a wall+paddle corner at (1,7).
    p1_pos = 3'd5;
    p2_pos = 3'd4;
    do_reset();
    cyc(10);
    expect_xy("before_p2_hit", 14, 4);
    cyc(1);
    expect_xy("p2_paddle_hit", 13, 3);
    check("hit_no_p1vic", p1vic, 0);
    cyc(1);
    expect_xy("after_hit_dx_neg", 12, 2);
    cyc(37);
    expect_xy("corner_arrive", 1, 7);
    cyc(1);
    expect_xy("corner_bounce", 2, 6);
    cyc(1);
    expect_xy("corner_leave", 3, 5);

    // Freeze mid-move, hold 100 cycles, then recentre and serve.
    p1_pos = 3'd0;
    p2_pos = 3'd0;
    do_reset();
    cyc(6);
    expect_xy("pre_freeze", 10, 6);
    game_over = 1'b1;
    cyc(100);
    expect_xy("frozen", 10, 6);
    check("frozen_p1vic", p1vic, 0);
    check("frozen_p2vic", p2vic, 0);
    game_over = 1'b0;
    cyc(1);
    expect_xy("unfreeze_recentre", 8, 4);
    cyc(4);
    expect_xy("unfreeze_serve", 8, 4);
    cyc(1);
    expect_xy("unfreeze_move", 9, 5);

    // Async reset mid-move, then mid-goal with a pulse pending.
    do_reset();
    cyc(6);
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    expect_xy("async_rst_move", 8, 4);
    check("async_rst_p1vic", p1vic, 0);
    check("async_rst_p2vic", p2vic, 0);
    check("async_rst_state", dut.state_q, SERVE);
    @(negedge clock);
    #2 rst_n = 1'b1;
    cyc(10);
    expect_xy("pre_goal", 14, 4);
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1;
    expect_xy("async_rst_goal", 8, 4);
    check("async_rst_goal_p1vic", p1vic, 0);
    cyc(1);
    check("pend_lost_in_rst", p1vic, 0);
    #2 rst_n = 1'b1;
    cyc(1);
    check("pend_lost_after_1", p1vic, 0);
    cyc(1);
    check("pend_lost_after_2", p1vic, 0);
    expect_xy("post_rst_serve", 8, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
